// File: rtl/tensor_dma_resp.sv
// Tensor-side DMA responder: loads operand banks A/B/W, drains result FIFO X.
// Define TDR_LEN_CHECK_EN to require received words == depth*width before marking a bank loaded.
module tensor_dma_resp #(
    parameter int DATAWIDTH  = 8,
    parameter int BANK_DEPTH = 16,
    parameter int RES_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    set,
    input  logic [DATAWIDTH-1:0]          depth_in,
    input  logic [DATAWIDTH-1:0]          width_in,
    input  logic                          busy,
    input  logic                          tensor_wen,
    input  logic                          tensor_ren,
    input  logic                          finished_transfer,
    input  logic [DATAWIDTH-1:0]          mem_data_in,
    output logic [DATAWIDTH-1:0]          mem_data_out,
    input  logic [1:0]                    rd_bank,
    input  logic [$clog2(BANK_DEPTH)-1:0] rd_addr,
    output logic [DATAWIDTH-1:0]          rd_data,
    input  logic                          res_push,
    input  logic [DATAWIDTH-1:0]          res_data,
    output logic                          res_full,
    output logic [$clog2(RES_DEPTH):0]    res_count,
    output logic [2:0]                    loaded,
    output logic                          err
);
    localparam int AW = $clog2(BANK_DEPTH);
    localparam int RW = $clog2(RES_DEPTH);
    localparam int CW = 2 * DATAWIDTH;
    localparam logic [AW:0] PTR_END = (AW+1)'(BANK_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [RW:0] RES_END = (RW+1)'(RES_DEPTH);
    localparam logic [RW:0] CNT_ONE = (RW+1)'(1);
    localparam logic [RW-1:0] RP_ONE = RW'(1);
    localparam logic [CW-1:0] RCV_ONE = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_busy_q;
    logic [1:0]           r_set;
    logic [CW-1:0]        r_expected;
    logic [CW-1:0]        r_rcv_cnt;
    logic [AW:0]          r_wr_ptr;
    logic [2:0]           r_loaded;
    logic                 r_err;
    logic [DATAWIDTH-1:0] r_rd_data;
    logic [DATAWIDTH-1:0] r_mem_out;
    logic [DATAWIDTH-1:0] r_bank [3][BANK_DEPTH];

    logic [DATAWIDTH-1:0] r_res_mem [RES_DEPTH];
    logic [RW-1:0]        r_res_wp;
    logic [RW-1:0]        r_res_rp;
    logic [RW:0]          r_res_cnt;

    logic w_busy_rise;
    logic w_busy_fall;
    logic w_start;
    logic w_wr_en;
    logic w_rcv;
    logic w_pop_req;
    logic w_err_set;
    logic w_ld_set;
    logic w_ld_clr;
    logic w_res_empty;
    logic w_res_full;
    logic w_pop_ok;
    logic w_pop_err;
    logic w_push_ok;
    logic w_push_err;

    // Banks A, B, W map to physical slots 0, 1, 2; set 2 (X) has no bank.
    function automatic logic [1:0] bank_idx(input logic [1:0] s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

    assign w_busy_rise = busy & ~r_busy_q;
    assign w_busy_fall = ~busy & r_busy_q;

`ifndef TDR_LEN_CHECK_EN
    logic w_unused_len;
    assign w_unused_len = ^{r_rcv_cnt, r_expected};
`endif

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_wr_en   = 1'b0;
        w_rcv     = 1'b0;
        w_pop_req = 1'b0;
        w_err_set = 1'b0;
        w_ld_set  = 1'b0;
        w_ld_clr  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_err_set = tensor_wen;
                if (w_busy_rise) begin
                    w_start = 1'b1;
                    if (set == 2'd2) begin
                        w_next = S_DRAIN;
                    end else begin
                        w_next   = S_LOAD;
                        w_ld_clr = 1'b1;
                    end
                end
            end
            S_LOAD, S_DRAIN: begin
                if (r_state == S_LOAD && tensor_wen) begin
                    w_rcv = 1'b1;
                    if (r_wr_ptr == PTR_END) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                    end
                end
                w_pop_req = (r_state == S_DRAIN) & tensor_ren;
                if (finished_transfer) begin
                    w_next = S_DONE;
                end else if (w_busy_fall) begin
                    w_next    = S_IDLE;
                    w_err_set = 1'b1;
                end
            end
            S_DONE: begin
                w_next    = S_IDLE;
                w_err_set = tensor_wen;
                if (r_set != 2'd2) begin
`ifdef TDR_LEN_CHECK_EN
                    if (r_rcv_cnt != r_expected) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_ld_set = 1'b1;
                    end
`else
                    w_ld_set = 1'b1;
`endif
                end
            end
        endcase
    end

    // A pop frees a slot this cycle, so a push into a full FIFO still lands.
    assign w_res_empty = (r_res_cnt == '0);
    assign w_res_full  = (r_res_cnt == RES_END);
    assign w_pop_ok    = w_pop_req & ~w_res_empty;
    assign w_pop_err   = w_pop_req & w_res_empty;
    assign w_push_ok   = res_push & (~w_res_full | w_pop_ok);
    assign w_push_err  = res_push & ~w_push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_q   <= 1'b0;
            r_set      <= '0;
            r_expected <= '0;
            r_rcv_cnt  <= '0;
            r_wr_ptr   <= '0;
            r_loaded   <= '0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_busy_q <= busy;
            r_err    <= r_err | w_err_set | w_pop_err | w_push_err;
            if (w_start) begin
                r_set      <= set;
                r_expected <= CW'(depth_in) * CW'(width_in);
                r_rcv_cnt  <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_rcv) begin
                    r_rcv_cnt <= r_rcv_cnt + RCV_ONE;
                end
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
            end
            if (w_ld_clr) begin
                r_loaded[bank_idx(set)] <= 1'b0;
            end
            if (w_ld_set) begin
                r_loaded[bank_idx(r_set)] <= 1'b1;
            end
            if (rd_bank == 2'd2) begin
                r_rd_data <= '0;
            end else begin
                r_rd_data <= r_bank[bank_idx(rd_bank)][rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_bank[bank_idx(r_set)][r_wr_ptr[AW-1:0]] <= mem_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_res_mem[r_res_wp] <= res_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_wp  <= '0;
            r_res_rp  <= '0;
            r_res_cnt <= '0;
            r_mem_out <= '0;
        end else begin
            if (w_push_ok) begin
                r_res_wp <= r_res_wp + RP_ONE;
            end
            if (w_pop_ok) begin
                r_res_rp  <= r_res_rp + RP_ONE;
                r_mem_out <= r_res_mem[r_res_rp];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_res_cnt <= r_res_cnt + CNT_ONE;
                2'b01:   r_res_cnt <= r_res_cnt - CNT_ONE;
                default: r_res_cnt <= r_res_cnt;
            endcase
        end
    end

    assign mem_data_out = r_mem_out;
    assign rd_data      = r_rd_data;
    assign res_count    = r_res_cnt;
    assign res_full     = w_res_full;
    assign loaded       = r_loaded;
    assign err          = r_err;
endmodule

// File: tb/tb_tensor_dma_resp.sv
// Bench for tensor_dma_resp: directed cases plus randomized transfers
// scored every cycle against a queue/array model of the responder.
module tb_tensor_dma_resp;
    localparam int DW = 8;
    localparam int BD = 16;
    localparam int RD = 16;
`ifdef TDR_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] set = '0;
    logic [DW-1:0] depth_in = '0;
    logic [DW-1:0] width_in = '0;
    logic busy = 1'b0;
    logic tensor_wen = 1'b0;
    logic tensor_ren = 1'b0;
    logic finished_transfer = 1'b0;
    logic [DW-1:0] mem_data_in = '0;
    logic [DW-1:0] mem_data_out;
    logic [1:0] rd_bank = '0;
    logic [$clog2(BD)-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic res_push = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic res_full;
    logic [$clog2(RD):0] res_count;
    logic [2:0] loaded;
    logic err;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    tensor_dma_resp #(.DATAWIDTH(DW), .BANK_DEPTH(BD), .RES_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .set(set),
        .depth_in(depth_in), .width_in(width_in),
        .busy(busy), .tensor_wen(tensor_wen), .tensor_ren(tensor_ren),
        .finished_transfer(finished_transfer),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .res_push(res_push), .res_data(res_data),
        .res_full(res_full), .res_count(res_count),
        .loaded(loaded), .err(err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transfer phase, a word queue for X and arrays for banks.
    localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;
    int ph = P_IDLE;
    logic [DW-1:0] kb [3][BD];
    bit kv [3][BD];
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_out = '0;
    logic [DW-1:0] m_rd = '0;
    bit m_rd_known = 1'b0;
    bit m_err = 1'b0;
    bit m_busy_prev = 1'b0;
    logic [2:0] m_loaded = '0;
    logic [1:0] tgt = '0;
    int ptr = 0;
    int rcv = 0;
    int expn = 0;

    function automatic int bix(input logic [1:0] s);
        return (s == 2'd3) ? 2 : int'(s);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = P_IDLE;
            m_err = 1'b0;
            m_loaded = '0;
            q.delete();
            m_out = '0;
            m_rd = '0;
            m_rd_known = 1'b1;
            m_busy_prev = 1'b0;
            ptr = 0;
            rcv = 0;
        end else begin
            if (rd_bank == 2'd2) begin
                m_rd = '0;
                m_rd_known = 1'b1;
            end else begin
                m_rd = kb[bix(rd_bank)][rd_addr];
                m_rd_known = kv[bix(rd_bank)][rd_addr];
            end
            if (ph == P_DRAIN && tensor_ren) begin
                if (q.size() == 0) m_err = 1'b1;
                else m_out = q.pop_front();
            end
            if (res_push) begin
                if (q.size() < RD) q.push_back(res_data);
                else m_err = 1'b1;
            end
            case (ph)
                P_IDLE: begin
                    if (tensor_wen) m_err = 1'b1;
                    if (busy && !m_busy_prev) begin
                        tgt = set;
                        expn = int'(depth_in) * int'(width_in);
                        ptr = 0;
                        rcv = 0;
                        if (set == 2'd2) begin
                            ph = P_DRAIN;
                        end else begin
                            m_loaded[bix(set)] = 1'b0;
                            ph = P_LOAD;
                        end
                    end
                end
                P_LOAD, P_DRAIN: begin
                    if (ph == P_LOAD && tensor_wen) begin
                        rcv++;
                        if (ptr >= BD) begin
                            m_err = 1'b1;
                        end else begin
                            kb[bix(tgt)][ptr] = mem_data_in;
                            kv[bix(tgt)][ptr] = 1'b1;
                            ptr++;
                        end
                    end
                    if (finished_transfer) begin
                        ph = P_DONE;
                    end else if (!busy && m_busy_prev) begin
                        ph = P_IDLE;
                        m_err = 1'b1;
                    end
                end
                default: begin
                    if (tensor_wen) m_err = 1'b1;
                    if (tgt != 2'd2) begin
                        if (LEN_CHK && rcv != expn) m_err = 1'b1;
                        else m_loaded[bix(tgt)] = 1'b1;
                    end
                    ph = P_IDLE;
                end
            endcase
            m_busy_prev = busy;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("err", {31'b0, err}, {31'b0, m_err});
            chk("loaded", {29'b0, loaded}, {29'b0, m_loaded});
            chk("res_count", {27'b0, res_count}, q.size());
            chk("res_full", {31'b0, res_full}, {31'b0, q.size() == RD});
            chk("mem_data_out", {24'b0, mem_data_out}, {24'b0, m_out});
            if (m_rd_known) chk("rd_data", {24'b0, rd_data}, {24'b0, m_rd});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        tensor_wen = 1'b0;
        tensor_ren = 1'b0;
        finished_transfer = 1'b0;
        res_push = 1'b0;
    endtask

    task automatic start(input logic [1:0] s, input int d, input int w);
        quiet();
        set = s;
        depth_in = DW'(d);
        width_in = DW'(w);
        busy = 1'b1;
        tick();
    endtask

    task automatic finish();
        quiet();
        finished_transfer = 1'b1;
        tick();
        finished_transfer = 1'b0;
        busy = 1'b0;
        tick();
    endtask

    task automatic wr(input int v);
        quiet();
        tensor_wen = 1'b1;
        mem_data_in = DW'(v);
        tick();
    endtask

    task automatic push(input int v);
        quiet();
        res_push = 1'b1;
        res_data = DW'(v);
        tick();
    endtask

    task automatic sync_reset();
        quiet();
        busy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic bg();
        res_push = ($urandom_range(0, 2) == 0);
        res_data = DW'($urandom);
        rd_bank = 2'($urandom_range(0, 3));
        rd_addr = 4'($urandom_range(0, 15));
    endtask

    task automatic rand_xfer();
        int s, d, w, n;
        s = $urandom_range(0, 3);
        d = $urandom_range(1, 4);
        w = $urandom_range(1, 5);
        n = d * w + $urandom_range(0, 3);
        quiet();
        bg();
        set = 2'(s);
        depth_in = DW'(d);
        width_in = DW'(w);
        busy = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            quiet();
            bg();
            tensor_wen = ($urandom_range(0, 3) != 0);
            mem_data_in = DW'($urandom);
            tensor_ren = ($urandom_range(0, 1) == 1);
            tick();
        end
        quiet();
        bg();
        if ($urandom_range(0, 7) == 0) begin
            busy = 1'b0;
            tick();
        end else begin
            finished_transfer = 1'b1;
            tensor_wen = ($urandom_range(0, 1) == 1);
            mem_data_in = DW'($urandom);
            tensor_ren = ($urandom_range(0, 1) == 1);
            tick();
            quiet();
            bg();
            busy = 1'b0;
            tensor_wen = ($urandom_range(0, 15) == 0);
            tick();
        end
        quiet();
        bg();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_loaded", {29'b0, loaded}, 0);
        chk("rst_count", {27'b0, res_count}, 0);
        chk("rst_out", {24'b0, mem_data_out}, 0);

        start(2'd0, 2, 3);
        for (int i = 0; i < 6; i++) wr(32'h10 + i);
        finish();
        chk("A_loaded", {29'b0, loaded}, 32'b001);
        chk("A_err", {31'b0, err}, 0);
        rd_bank = 2'd0;
        rd_addr = 4'd4;
        tick();
        chk("A_rd4", {24'b0, rd_data}, 32'h14);

        for (int i = 0; i < 3; i++) push(32'hA1 + i);
        chk("X_count3", {27'b0, res_count}, 3);
        start(2'd2, 1, 3);
        for (int i = 0; i < 3; i++) begin
            quiet();
            tensor_ren = 1'b1;
            tick();
            chk("X_pop", {24'b0, mem_data_out}, 32'hA1 + i);
        end
        finish();
        chk("X_count0", {27'b0, res_count}, 0);
        chk("X_err", {31'b0, err}, 0);

        start(2'd3, 4, 4);
        for (int i = 0; i < 17; i++) wr(32'h30 + i);
        finish();
        chk("W_err", {31'b0, err}, 1);
        rd_bank = 2'd3;
        rd_addr = 4'd15;
        tick();
        chk("W_rd15", {24'b0, rd_data}, 32'h3F);

        sync_reset();
        push(32'h5C);
        start(2'd2, 1, 1);
        quiet();
        tensor_ren = 1'b1;
        tick();
        chk("U_first", {24'b0, mem_data_out}, 32'h5C);
        chk("U_err0", {31'b0, err}, 0);
        quiet();
        tensor_ren = 1'b1;
        tick();
        chk("U_err", {31'b0, err}, 1);
        chk("U_hold", {24'b0, mem_data_out}, 32'h5C);
        finish();
        for (int i = 0; i < 16; i++) push(32'h60 + i);
        chk("F_full", {31'b0, res_full}, 1);
        chk("F_count", {27'b0, res_count}, 16);
        start(2'd2, 1, 1);
        quiet();
        tensor_ren = 1'b1;
        res_push = 1'b1;
        res_data = 8'h99;
        tick();
        chk("F_both_count", {27'b0, res_count}, 16);
        chk("F_both_out", {24'b0, mem_data_out}, 32'h60);
        finish();

        sync_reset();
        start(2'd1, 2, 2);
        for (int i = 0; i < 3; i++) wr(32'h20 + i);
        finish();
`ifdef TDR_LEN_CHECK_EN
        chk("L_err", {31'b0, err}, 1);
        chk("L_loaded1", {31'b0, loaded[1]}, 0);
`else
        chk("L_err", {31'b0, err}, 0);
        chk("L_loaded1", {31'b0, loaded[1]}, 1);
`endif

        start(2'd3, 2, 2);
        for (int i = 0; i < 4; i++) wr(32'h70 + i);
        finish();
        push(32'h11);
        push(32'h22);
        wr(32'h33);
        start(2'd0, 2, 2);
        wr(32'h01);
        wr(32'h02);
        quiet();
        chk("R_pre_err", {31'b0, err}, 1);
        chk("R_pre_w", {31'b0, loaded[2]}, 1);
        chk("R_pre_count", {27'b0, res_count}, 2);
        #2 rst = 1'b1;
        #1;
        chk("R_err", {31'b0, err}, 0);
        chk("R_loaded", {29'b0, loaded}, 0);
        chk("R_count", {27'b0, res_count}, 0);
        busy = 1'b0;
        tick();
        rst = 1'b0;

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0) sync_reset();
            rand_xfer();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tensor_dma_resp.md
Name: tensor_dma_resp

Overview:
Tensor-side responder to the DMA controller's tensor interface: set, depth/width, tensor_wen, tensor_ren, busy, finished_transfer.
- Load transfers (set A=0, B=1, W=3) write streamed memory words into per-set operand banks.
- Pop transfers (set X=2) drain a result FIFO filled by the tensor compute array.
- Reports per-bank loaded status and a sticky error flag to the compute core.

Parameters:
DATAWIDTH, 8, width of data words and of depth/width dimensions
BANK_DEPTH, 16, entries per operand bank (A, B, W)
RES_DEPTH, 16, entries in result FIFO (power of 2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
set  input  2  transfer target: 0=A, 1=B, 2=X(pop), 3=W
depth_in  input  DATAWIDTH  column dimension of transfer
width_in  input  DATAWIDTH  row dimension of transfer
busy  input  1  DMA busy
tensor_wen  input  1  write strobe; mem_data_in valid this cycle
tensor_ren  input  1  pop strobe for result FIFO
finished_transfer  input  1  DMA completion pulse
mem_data_in  input  DATAWIDTH  word from memory for load transfers
mem_data_out  output  DATAWIDTH  popped result word
rd_bank  input  2  compute read bank select: 0=A, 1=B, 3=W
rd_addr  input  $clog2(BANK_DEPTH)  compute read address
rd_data  output  DATAWIDTH  bank read data, registered
res_push  input  1  compute pushes res_data into result FIFO
res_data  input  DATAWIDTH  result word
res_full  output  1  result FIFO full
res_count  output  $clog2(RES_DEPTH)+1  result FIFO occupancy
loaded  output  3  bit0=A, bit1=B, bit2=W bank holds a complete load
err  output  1  sticky error

Behaviour:
- Reset, async: all outputs 0, state IDLE, pointers and counters 0. Bank contents are not cleared.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - On a busy rising edge, latch set, expected = depth_in*width_in (2*DATAWIDTH bits) and wr_ptr=0.
  - set≠2: go to LOAD and clear the loaded bit of the target bank.
  - set==2: go to DRAIN.
- LOAD:
  - Each tensor_wen cycle writes mem_data_in to bank[set][wr_ptr] on the same edge; wr_ptr and rcv_cnt increment.
  - A write with wr_ptr==BANK_DEPTH is dropped and sets err. wr_ptr saturates; it does not wrap.
- DRAIN:
  - Each tensor_ren cycle pops the FIFO head; mem_data_out is updated on the following edge (1-cycle latency) and holds otherwise.
  - A pop while empty leaves mem_data_out unchanged and sets err.
- Exit from LOAD or DRAIN: finished_transfer goes to DONE. A strobe in the same cycle as finished_transfer is still processed.
- DONE, one cycle:
  - For LOAD, set the loaded bit of the target bank.
  - Return to IDLE.
- Strobes received in IDLE or DONE are ignored; a tensor_wen in IDLE/DONE sets err.
- busy falling without finished_transfer while in LOAD/DRAIN: return to IDLE, loaded bit stays clear, err set.
- Result FIFO:
  - res_push while full is dropped and sets err.
  - Push and pop in the same cycle with full: both happen, count unchanged.
  - Push and pop in the same cycle with empty: pop underflows (no bypass, err), push stored.
- res_full = (res_count==RES_DEPTH).
- Banks: rd_data = bank[rd_bank][rd_addr], registered, 1-cycle latency. rd_bank==2 returns 0.
- Read and write to the same bank and address in the same cycle returns old data.
- err clears only on rst.

Optional Feature:
Macro TDR_LEN_CHECK_EN.
- Defined: in DONE after LOAD, if rcv_cnt≠expected, set err and leave the loaded bit clear.
- Undefined: no length check; the loaded bit is always set in DONE after LOAD.

Test Plan:
- Load A: depth_in=2, width_in=3, busy↑, 6 tensor_wen with data 0x10..0x15, finished_transfer -> loaded=3'b001 two cycles after finished; rd_bank=0, rd_addr=4 gives rd_data=0x14 next cycle; err=0.
- Pop X: push 0xA1,0xA2,0xA3, set=2, busy↑, 3 tensor_ren -> mem_data_out 0xA1,0xA2,0xA3 on successive cycles; res_count back to 0; err=0.
- Overflow: load W with 17 tensor_wen, BANK_DEPTH=16 -> 17th write dropped, bank W entry 15 intact, err=1.
- Underflow and full: tensor_ren on empty FIFO -> err=1, mem_data_out unchanged. 16 pushes -> res_full=1; a 17th push combined with a pop -> res_count stays 16.
- Length check: depth=2, width=2, only 3 writes, then finished -> with TDR_LEN_CHECK_EN: err=1, loaded[1]=0; without: loaded[1]=1, err=0.
- Reset mid-LOAD: assert rst asynchronously after 2 writes -> state IDLE, loaded=0, err=0, res_count=0 immediately, without waiting for a clock edge.
